// File: rtl/sfu_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : sfu_ctrl
//  Function : Sequencer for the SFU/PMEM datapath. A store moves NUM_OUT
//             OFIFO entries through the SFU bypass path into one PMEM
//             kernel-position slice. An accumulate sweeps every output pixel,
//             sums its NUM_KIJ partial sums in the SFU, applies ReLU and
//             writes the result above the partial-sum region.
//  Revision : 1.0  initial release
// ============================================================================
module sfu_ctrl #(
    parameter int NUM_OUT = 16,
    parameter int NUM_KIJ = 9,
    parameter int ADDR_BW = 11
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start_store,
    input  logic [3:0]         kij_idx,
    input  logic               start_acc,
    input  logic               ofifo_valid,
    output logic               ofifo_rd,
    output logic               sfu_bypass,
    output logic               sfu_acc,
    output logic               pmem_ren,
    output logic               pmem_wen,
    output logic [ADDR_BW-1:0] pmem_addr,
    output logic               busy,
    output logic               done,
    output logic               err
);

    localparam int CNT_W = $clog2(NUM_OUT + 1);
    localparam int O_W   = (NUM_OUT > 1) ? $clog2(NUM_OUT) : 1;
    localparam int K_W   = (NUM_KIJ > 1) ? $clog2(NUM_KIJ) : 1;

    localparam logic [2:0] IDLE     = 3'd0;
    localparam logic [2:0] ST_RUN   = 3'd1;
    localparam logic [2:0] ST_DRAIN = 3'd2;
    localparam logic [2:0] A_READ   = 3'd3;
    localparam logic [2:0] A_LAST   = 3'd4;
    localparam logic [2:0] A_RELU   = 3'd5;
    localparam logic [2:0] A_WRITE  = 3'd6;
    localparam logic [2:0] DONE     = 3'd7;

    // Result region sits directly above the NUM_KIJ partial-sum slices.
    localparam logic [ADDR_BW-1:0] c_RES_BASE = ADDR_BW'(NUM_KIJ * NUM_OUT);

    logic [2:0]         state_q, state_d;
    logic [CNT_W-1:0]   cnt_q,   cnt_d;
    logic [O_W-1:0]     o_q,     o_d;
    logic [K_W-1:0]     k_q,     k_d;
    logic [ADDR_BW-1:0] base_q,  base_d;
    logic               drain_q, drain_d;
    logic               err_q,   err_d;

    // Store pipeline: pop stage -> bypass stage -> write stage.
    logic               byp_q;
    logic               wr_q;
    logic [ADDR_BW-1:0] paddr_q;
    logic [ADDR_BW-1:0] waddr_q;

    logic               w_pop;
    logic               w_kij_ok;

    assign w_pop    = (state_q == ST_RUN) && ofifo_valid;
    assign w_kij_ok = (32'(kij_idx) < NUM_KIJ);

    // Next-state and counter control for both the store and accumulate flows.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        o_d     = o_q;
        k_d     = k_q;
        base_d  = base_q;
        drain_d = drain_q;
        err_d   = 1'b0;
        case (state_q)
            IDLE: begin
                // A store request takes priority; a simultaneous acc is dropped.
                if (start_store) begin
                    if (w_kij_ok) begin
                        state_d = ST_RUN;
                        cnt_d   = '0;
                        drain_d = 1'b0;
                        base_d  = ADDR_BW'(kij_idx) * ADDR_BW'(NUM_OUT);
                    end else begin
                        err_d = 1'b1;
                    end
                end else if (start_acc) begin
                    state_d = A_READ;
                    o_d     = '0;
                    k_d     = '0;
                end
            end
            ST_RUN: begin
                if (ofifo_valid) begin
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_W'(NUM_OUT - 1)) begin
                        state_d = ST_DRAIN;
                        drain_d = 1'b0;
                    end
                end
            end
            ST_DRAIN: begin
                // Two cycles let the last popped entry reach the PMEM write.
                if (drain_q) begin
                    state_d = DONE;
                end else begin
                    drain_d = 1'b1;
                end
            end
            A_READ: begin
                if (k_q == K_W'(NUM_KIJ - 1)) begin
                    k_d     = '0;
                    state_d = A_LAST;
                end else begin
                    k_d = k_q + K_W'(1);
                end
            end
            A_LAST:  state_d = A_RELU;
            A_RELU:  state_d = A_WRITE;
            A_WRITE: begin
                if (o_q == O_W'(NUM_OUT - 1)) begin
                    o_d     = '0;
                    state_d = DONE;
                end else begin
                    o_d     = o_q + O_W'(1);
                    state_d = A_READ;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Control state registers; reset aborts any operation in progress.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            o_q     <= '0;
            k_q     <= '0;
            base_q  <= '0;
            drain_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            o_q     <= o_d;
            k_q     <= k_d;
            base_q  <= base_d;
            drain_q <= drain_d;
            err_q   <= err_d;
        end
    end

    // Store pipeline: each pop becomes a bypass one cycle later and a write two cycles later.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            byp_q   <= 1'b0;
            wr_q    <= 1'b0;
            paddr_q <= '0;
            waddr_q <= '0;
        end else begin
            byp_q <= w_pop;
            wr_q  <= byp_q;
            if (w_pop) begin
                paddr_q <= base_q + ADDR_BW'(cnt_q);
            end
            if (byp_q) begin
                waddr_q <= paddr_q;
            end
        end
    end

    // Output decode from state and the store pipeline.
    always_comb begin
        ofifo_rd   = w_pop;
        sfu_bypass = byp_q;
        sfu_acc    = ((state_q == A_READ) && (k_q != '0)) || (state_q == A_LAST);
        pmem_ren   = (state_q == A_READ);
        pmem_wen   = wr_q || (state_q == A_WRITE);
        pmem_addr  = '0;
        if (state_q == A_READ) begin
            pmem_addr = ADDR_BW'(k_q) * ADDR_BW'(NUM_OUT) + ADDR_BW'(o_q);
        end else if (state_q == A_WRITE) begin
            pmem_addr = c_RES_BASE + ADDR_BW'(o_q);
        end else if (wr_q) begin
            pmem_addr = waddr_q;
        end
        busy = (state_q != IDLE);
        done = (state_q == DONE);
        err  = err_q;
    end

endmodule
`default_nettype wire

// File: tb/tb_sfu_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_sfu_ctrl
//  Function : Directed self-checking bench for sfu_ctrl with a small
//             OFIFO / PMEM / SFU behavioural model around the controller.
//  Revision : 1.0  initial release
// ============================================================================
module tb_sfu_ctrl;

    typedef struct {
        logic [3:0] kij;
        logic       toggle;
        logic       both;
        logic       mid_acc;
        logic       exp_err;
        int         exp_base;
    } vec_t;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start_store = 1'b0;
    logic [3:0]  kij_idx = 4'd0;
    logic        start_acc = 1'b0;
    logic        ofifo_valid = 1'b0;
    logic        ofifo_rd, sfu_bypass, sfu_acc, pmem_ren, pmem_wen;
    logic [10:0] pmem_addr;
    logic        busy, done, err;

    int n_cmp = 0;
    int n_bad = 0;

    // OFIFO / PMEM / SFU model state
    int mem [0:2047];
    int rdata = 0;
    int acc = 0;
    int outr = 0;
    int fifo_q = 100;

    vec_t vecs [7];

    sfu_ctrl #(.NUM_OUT(16), .NUM_KIJ(9), .ADDR_BW(11)) dut (
        .clk(clk), .reset(reset), .start_store(start_store), .kij_idx(kij_idx),
        .start_acc(start_acc), .ofifo_valid(ofifo_valid), .ofifo_rd(ofifo_rd),
        .sfu_bypass(sfu_bypass), .sfu_acc(sfu_acc), .pmem_ren(pmem_ren),
        .pmem_wen(pmem_wen), .pmem_addr(pmem_addr), .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    // Behavioural OFIFO, PMEM (1-cycle read) and SFU (bypass / acc / ReLU).
    always @(posedge clk) begin
        if (pmem_wen) mem[pmem_addr] = outr;
        if (pmem_ren) rdata <= mem[pmem_addr];
        if (sfu_bypass) begin
            outr <= fifo_q;
        end else if (sfu_acc) begin
            acc <= acc + rdata;
        end else begin
            outr <= (acc > 0) ? acc : 0;
            acc  <= 0;
        end
        if (ofifo_rd) fifo_q <= fifo_q + 1;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [17:0] pk();
        return {busy, done, pmem_ren, pmem_wen, sfu_acc, sfu_bypass, ofifo_rd, pmem_addr};
    endfunction

    function automatic logic [17:0] ex(input logic b, input logic d, input logic r,
                                       input logic w, input logic a, input int addr);
        logic [10:0] ad;
        ad = addr[10:0];
        return {b, d, r, w, a, 1'b0, 1'b0, ad};
    endfunction

    // Let combinational outputs settle, then check the always-true invariants.
    task automatic settle();
        #1;
        if (reset) begin
            chk("inv_ren_and_wen", 32'(pmem_ren & pmem_wen), 0);
            chk("inv_rd_without_valid", 32'(ofifo_rd & ~ofifo_valid), 0);
        end
    endtask

    task automatic run_store(input vec_t v);
        int pops[$];
        int cyc, nwr, nerr, err_cyc, ndone, done_cyc, nren, f0, wbad, last_pop;
        f0 = fifo_q; nwr = 0; nerr = 0; err_cyc = -1; ndone = 0; done_cyc = -1;
        nren = 0; wbad = 0; last_pop = -100;
        @(negedge clk);
        start_store = 1'b1; kij_idx = v.kij; start_acc = v.both; ofifo_valid = 1'b0;
        settle();
        cyc = 0;
        while (done_cyc < 0 && cyc < 60 && !(v.exp_err && cyc >= 4)) begin
            cyc++;
            @(negedge clk);
            start_store = 1'b0;
            start_acc   = v.mid_acc && (cyc == 5);
            ofifo_valid = v.toggle ? (cyc % 2 == 1) : 1'b1;
            settle();
            if (ofifo_rd) begin pops.push_back(cyc); last_pop = cyc; end
            if (pmem_wen) begin
                if (nwr < pops.size()) begin
                    chk("store_waddr", 32'(pmem_addr), v.exp_base + nwr);
                    chk("store_wlatency", cyc, pops[nwr] + 2);
                end else begin
                    chk("store_write_without_pop", 1, 0);
                end
                nwr++;
            end
            if (pmem_ren) nren++;
            if (err)  begin nerr++;  err_cyc = cyc;  end
            if (done) begin ndone++; done_cyc = cyc; end
        end
        start_acc = 1'b0; ofifo_valid = 1'b0;
        @(negedge clk); settle();
        chk("store_idle_after", 32'(busy), 0);
        chk("store_pops", pops.size(), v.exp_err ? 0 : 16);
        chk("store_writes", nwr, v.exp_err ? 0 : 16);
        chk("store_err_pulses", nerr, v.exp_err ? 1 : 0);
        chk("store_err_cycle", err_cyc, v.exp_err ? 1 : -1);
        chk("store_done_cycle", done_cyc, v.exp_err ? -1 : last_pop + 3);
        chk("store_no_pmem_read", nren, 0);
        if (!v.exp_err) begin
            for (int i = 0; i < 16; i++)
                if (mem[v.exp_base + i] != f0 + i + 1) wbad++;
            chk("store_data_entries_bad", wbad, 0);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int pv;
        int exp_res;
        logic [17:0] e;
        for (int i = 0; i < 2048; i++) mem[i] = 0;
        //            kij  tog  both mid  err  base
        vecs[0] = '{4'd2,  1'b0, 1'b0, 1'b0, 1'b0, 32};
        vecs[1] = '{4'd2,  1'b1, 1'b0, 1'b0, 1'b0, 32};
        vecs[2] = '{4'd1,  1'b0, 1'b1, 1'b0, 1'b0, 16};
        vecs[3] = '{4'd8,  1'b0, 1'b0, 1'b1, 1'b0, 128};
        vecs[4] = '{4'd0,  1'b1, 1'b0, 1'b0, 1'b0, 0};
        vecs[5] = '{4'd9,  1'b0, 1'b0, 1'b0, 1'b1, 0};
        vecs[6] = '{4'd15, 1'b0, 1'b0, 1'b0, 1'b1, 0};

        // Reset state
        @(negedge clk); #1;
        chk("reset_outputs", 32'(pk()), 0);
        chk("reset_err", 32'(err), 0);
        @(negedge clk); reset = 1'b1; settle();
        chk("idle_outputs", 32'(pk()), 0);

        // Store vectors
        for (int v = 0; v < 7; v++) run_store(vecs[v]);

        // Accumulate sweep: pixel 0 sums to -5, pixel 1 to +7, others to +9
        for (int k = 0; k < 9; k++)
            for (int o = 0; o < 16; o++) begin
                if (o == 0)      pv = (k == 0) ? -13 : 1;
                else if (o == 1) pv = (k == 0) ? -1 : 1;
                else             pv = k - 3;
                mem[k*16 + o] = pv;
            end
        for (int o = 0; o < 16; o++) mem[144 + o] = -1;
        @(negedge clk); start_acc = 1'b1; settle();
        for (int j = 0; j <= 193; j++) begin
            @(negedge clk); start_acc = 1'b0; settle();
            e = '0;
            if (j < 192) begin
                int o, p;
                o = j / 12; p = j % 12;
                if (p < 9)       e = ex(1, 0, 1, 0, p != 0, p*16 + o);
                else if (p == 9) e = ex(1, 0, 0, 0, 1, 0);
                else if (p == 10) e = ex(1, 0, 0, 0, 0, 0);
                else             e = ex(1, 0, 0, 1, 0, 144 + o);
            end else if (j == 192) begin
                e = ex(1, 1, 0, 0, 0, 0);
            end
            chk($sformatf("acc_cycle_%0d", j), 32'(pk()), 32'(e));
        end
        for (int o = 0; o < 16; o++) begin
            exp_res = (o == 0) ? 0 : (o == 1) ? 7 : 9;
            chk($sformatf("acc_result_%0d", o), mem[144 + o], exp_res);
        end

        // Reset in the middle of A_READ, then restart from o=0, k=0
        @(negedge clk); start_acc = 1'b1; settle();
        @(negedge clk); start_acc = 1'b0; settle();
        @(negedge clk); settle();
        @(negedge clk); settle();
        reset = 1'b0; #1;
        chk("midreset_outputs", 32'(pk()), 0);
        chk("midreset_err", 32'(err), 0);
        @(negedge clk); reset = 1'b1; start_acc = 1'b1; settle();
        @(negedge clk); start_acc = 1'b0; settle();
        chk("restart_k0", 32'(pk()), 32'(ex(1, 0, 1, 0, 0, 0)));
        @(negedge clk); settle();
        chk("restart_k1", 32'(pk()), 32'(ex(1, 0, 1, 0, 1, 16)));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
